// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the architectural PC, fetches words over a req/ack memory port, hands them to decode.
// Latency: FETCH -> ack (>=1 cycle after req) -> HOLD; best case one instruction every 3 cycles.
// Backpressure: a held instruction stays stable until instrValid && instrReady && !stall; no new fetch until then.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   shouldUseNewPC,     redirect from the Branch unit; new pc = branchTo + 4
//   branchTo
//   stall               blocks decode acceptance
//   imemReq/imemAddr    fetch request (held until imemAck) and word-aligned address
//   imemAck/imemRdata   response strobe and fetched word
//   instr/instrPC/      instruction to decode, its address, and valid
//   instrValid/instrReady
//   fetchError          sticky timeout fault, cleared only by reset
//
// Build option: define MIPS_DELAY_SLOT_EN to deliver the instruction after a branch
// (delay slot) instead of squashing it; the redirect then takes effect on acceptance.

module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        shouldUseNewPC,
  input  logic [31:0] branchTo,
  input  logic        stall,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  output logic [31:0] instr,
  output logic [31:0] instrPC,
  output logic        instrValid,
  input  logic        instrReady,
  output logic        fetchError
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state, state_n;
  logic [31:0]   pc, pc_n;
  logic [31:0]   instr_n, ipc_n;
  logic          ivld_n, err_n;
  logic          squash, squash_n;
  logic [CW-1:0] tcnt, tcnt_n;
  // gap forces imemReq low for one cycle after a dropped response so the
  // memory sees a fresh request at the redirected address.
  logic          gap, gap_n;
  // addr_hold keeps imemAddr frozen while a request is outstanding; a redirect
  // moves pc but cannot retarget a request already presented to memory.
  logic          addr_hold;
  logic [31:0]   req_addr;

  logic          ack, accept, drop;
  logic [31:0]   redirect_pc;

`ifdef MIPS_DELAY_SLOT_EN
  logic          pend, pend_n;
  logic [31:0]   ptgt, ptgt_n;
`endif

  assign imemReq     = (state == S_FETCH) && !gap;
  assign imemAddr    = addr_hold ? req_addr : {pc[31:2], 2'b00};
  assign ack         = imemReq && imemAck;
  assign accept      = (state == S_HOLD) && instrValid && instrReady && !stall;
  assign redirect_pc = branchTo + 32'd4;

`ifdef MIPS_DELAY_SLOT_EN
  assign drop = 1'b0;
`else
  // A response is discarded if it belongs to a squashed request or a redirect
  // arrives in the same cycle as the ack.
  assign drop = squash || shouldUseNewPC;
`endif

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    instr_n  = instr;
    ipc_n    = instrPC;
    ivld_n   = instrValid;
    err_n    = fetchError;
    squash_n = squash;
    tcnt_n   = tcnt;
    gap_n    = 1'b0;
`ifdef MIPS_DELAY_SLOT_EN
    pend_n   = pend;
    ptgt_n   = ptgt;
`endif

    case (state)
      S_IDLE: begin
        state_n = S_FETCH;
        tcnt_n  = '0;
        if (shouldUseNewPC) pc_n = redirect_pc;
      end

      S_FETCH: begin
        if (ack) begin
          tcnt_n = '0;
          if (drop) begin
            squash_n = 1'b0;
            gap_n    = 1'b1;
          end else begin
            instr_n = imemRdata;
            ipc_n   = {pc[31:2], 2'b00};
            ivld_n  = 1'b1;
            pc_n    = pc + 32'd4;
            state_n = S_HOLD;
          end
        end else if (tcnt == TO_LAST) begin
          state_n  = S_ERROR;
          err_n    = 1'b1;
          ivld_n   = 1'b0;
          squash_n = 1'b0;
        end else begin
          tcnt_n = tcnt + CW'(1);
`ifndef MIPS_DELAY_SLOT_EN
          // Only a request actually on the bus needs its response squashed.
          if (shouldUseNewPC && imemReq) squash_n = 1'b1;
`endif
        end
`ifdef MIPS_DELAY_SLOT_EN
        if (shouldUseNewPC) begin
          pend_n = 1'b1;
          ptgt_n = branchTo;
        end
`else
        if (shouldUseNewPC) pc_n = redirect_pc;
`endif
      end

      S_HOLD: begin
        if (accept) begin
          ivld_n  = 1'b0;
          state_n = S_FETCH;
          tcnt_n  = '0;
        end
`ifdef MIPS_DELAY_SLOT_EN
        if (accept && (shouldUseNewPC || pend)) begin
          pc_n   = (shouldUseNewPC ? branchTo : ptgt) + 32'd4;
          pend_n = 1'b0;
        end else if (shouldUseNewPC) begin
          pend_n = 1'b1;
          ptgt_n = branchTo;
        end
`else
        if (shouldUseNewPC) begin
          pc_n    = redirect_pc;
          ivld_n  = 1'b0;
          state_n = S_FETCH;
          tcnt_n  = '0;
        end
`endif
      end

      default: begin
        // S_ERROR: terminal until reset; redirects ignored.
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc         <= RESET_VECTOR;
      instr      <= '0;
      instrPC    <= '0;
      instrValid <= 1'b0;
      fetchError <= 1'b0;
      squash     <= 1'b0;
      tcnt       <= '0;
      gap        <= 1'b0;
      addr_hold  <= 1'b0;
      req_addr   <= '0;
`ifdef MIPS_DELAY_SLOT_EN
      pend       <= 1'b0;
      ptgt       <= '0;
`endif
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      instr      <= instr_n;
      instrPC    <= ipc_n;
      instrValid <= ivld_n;
      fetchError <= err_n;
      squash     <= squash_n;
      tcnt       <= tcnt_n;
      gap        <= gap_n;
      addr_hold  <= imemReq && !imemAck && (state_n == S_FETCH);
      req_addr   <= imemAddr;
`ifdef MIPS_DELAY_SLOT_EN
      pend       <= pend_n;
      ptgt       <= ptgt_n;
`endif
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        shouldUseNewPC;
  logic [31:0] branchTo;
  logic        stall;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic [31:0] instr;
  logic [31:0] instrPC;
  logic        instrValid;
  logic        instrReady;
  logic        fetchError;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // memory model state
  int          lat = 1;
  int          wcnt = 0;
  logic [31:0] last_addr = '0;

  pc_fetch_unit #(
    .RESET_VECTOR  (32'h0040_0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .shouldUseNewPC(shouldUseNewPC),
    .branchTo      (branchTo),
    .stall         (stall),
    .imemReq       (imemReq),
    .imemAddr      (imemAddr),
    .imemAck       (imemAck),
    .imemRdata     (imemRdata),
    .instr         (instr),
    .instrPC       (instrPC),
    .instrValid    (instrValid),
    .instrReady    (instrReady),
    .fetchError    (fetchError)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: ack arrives once the request has been seen for 'lat' prior cycles.
  task automatic mem_update();
    if (imemReq) begin
      last_addr = imemAddr;
      if (wcnt >= lat) begin
        imemAck   = 1'b1;
        imemRdata = mem_word(imemAddr);
      end else begin
        imemAck = 1'b0;
      end
      wcnt++;
    end else begin
      wcnt    = 0;
      imemAck = 1'b0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    mem_update();
  endtask

  task automatic wait_valid(input string tag, input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (instrValid) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chk({tag, "_arrived"}, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int  nreq;
    bit  saw_valid;

    rst            = 1'b0;
    shouldUseNewPC = 1'b0;
    branchTo       = '0;
    stall          = 1'b0;
    imemAck        = 1'b0;
    imemRdata      = '0;
    instrReady     = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'd0, imemReq},    32'd0);
    chk("rst_addr",  imemAddr,            32'h0040_0000);
    chk("rst_instr", instr,               32'd0);
    chk("rst_ipc",   instrPC,             32'd0);
    chk("rst_vld",   {31'd0, instrValid}, 32'd0);
    chk("rst_err",   {31'd0, fetchError}, 32'd0);

    rst = 1'b1;
    mem_update();

    // 1: sequential fetch with one-cycle memory latency
    wait_valid("seq0", 10);
    chk("seq0_pc",    instrPC,   32'h0040_0000);
    chk("seq0_addr",  last_addr, 32'h0040_0000);
    chk("seq0_instr", instr,     mem_word(32'h0040_0000));
    cyc();
    wait_valid("seq1", 10);
    chk("seq1_pc",    instrPC,   32'h0040_0004);
    chk("seq1_addr",  last_addr, 32'h0040_0004);
    chk("seq1_instr", instr,     mem_word(32'h0040_0004));
    cyc();
    instrReady = 1'b0;
    wait_valid("seq2", 10);
    chk("seq2_pc",    instrPC,   32'h0040_0008);
    chk("seq2_addr",  last_addr, 32'h0040_0008);
    chk("seq2_instr", instr,     mem_word(32'h0040_0008));

    // 4: stall holds the instruction in HOLD even with decode ready
    stall      = 1'b1;
    instrReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_vld",   {31'd0, instrValid}, 32'd1);
      chk("stall_pc",    instrPC,             32'h0040_0008);
      chk("stall_instr", instr,               mem_word(32'h0040_0008));
      chk("stall_req",   {31'd0, imemReq},    32'd0);
    end
    stall      = 1'b0;
    instrReady = 1'b0;

    // 2: redirect while holding an unaccepted instruction discards it
    shouldUseNewPC = 1'b1;
    branchTo       = 32'h0000_1000;
    cyc();
    shouldUseNewPC = 1'b0;
    chk("redir_hold_vld",  {31'd0, instrValid}, 32'd0);
    chk("redir_hold_req",  {31'd0, imemReq},    32'd1);
    chk("redir_hold_addr", imemAddr,            32'h0000_1004);
    instrReady = 1'b1;
    wait_valid("redir_hold", 10);
    chk("redir_hold_pc",    instrPC, 32'h0000_1004);
    chk("redir_hold_instr", instr,   mem_word(32'h0000_1004));

    // 3: redirect during a 3-cycle fetch squashes that response
    lat = 3;
    cyc();
    chk("sq_first_addr", imemAddr, 32'h0000_1008);
    shouldUseNewPC = 1'b1;
    branchTo       = 32'h0000_2000;
    cyc();
    shouldUseNewPC = 1'b0;
    chk("sq_inflight_addr", imemAddr, 32'h0000_1008);
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!imemReq) break;
      saw_valid |= instrValid;
      cyc();
    end
    chk("sq_gap_req",  {31'd0, imemReq},    32'd0);
    chk("sq_no_vld",   {31'd0, saw_valid},  32'd0);
    chk("sq_gap_vld",  {31'd0, instrValid}, 32'd0);
    cyc();
    chk("sq_refetch_req",  {31'd0, imemReq}, 32'd1);
    chk("sq_refetch_addr", imemAddr,         32'h0000_2004);
    wait_valid("sq", 12);
    chk("sq_pc",    instrPC, 32'h0000_2004);
    chk("sq_instr", instr,   mem_word(32'h0000_2004));

    // 6: redirect accepted in the same cycle as delivery, then PC wraps
    lat            = 1;
    shouldUseNewPC = 1'b1;
    branchTo       = 32'hFFFF_FFF8;
    cyc();
    shouldUseNewPC = 1'b0;
    chk("wrap_vld",  {31'd0, instrValid}, 32'd0);
    chk("wrap_addr", imemAddr,            32'hFFFF_FFFC);
    wait_valid("wrap0", 10);
    chk("wrap0_pc", instrPC, 32'hFFFF_FFFC);
    cyc();
    wait_valid("wrap1", 10);
    chk("wrap1_pc",    instrPC, 32'h0000_0000);
    chk("wrap1_instr", instr,   mem_word(32'h0000_0000));

    // 5: memory never acknowledges -> sticky fault after 16 request cycles
    lat = 100000;
    cyc();
    nreq = 0;
    for (int i = 0; i < 40; i++) begin
      if (fetchError) break;
      if (imemReq) nreq++;
      cyc();
    end
    chk("to_cycles", nreq,                32'd16);
    chk("to_err",    {31'd0, fetchError}, 32'd1);
    chk("to_req",    {31'd0, imemReq},    32'd0);
    chk("to_vld",    {31'd0, instrValid}, 32'd0);
    shouldUseNewPC = 1'b1;
    branchTo       = 32'h0000_3000;
    repeat (3) cyc();
    shouldUseNewPC = 1'b0;
    chk("to_sticky_err", {31'd0, fetchError}, 32'd1);
    chk("to_sticky_req", {31'd0, imemReq},    32'd0);
    rst = 1'b0;
    #1;
    chk("to_rst_err",  {31'd0, fetchError}, 32'd0);
    chk("to_rst_addr", imemAddr,            32'h0040_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
